// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter: datapath width and FSM encoding.
package adder_share_pkg;

  // Width of operands, adder ports and the returned sum.
  localparam int DATA_W = 32;

  // FSM encoding. The unused code 2'd3 is steered back to IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest legal tag width for a given requester count (never below 1).
  function automatic int tag_width(input int nreq);
    return (nreq > 2) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid requester at or after ptr, cyclic.
// Produces a one-hot grant, its binary index and a flag that any request is present.
module rr_grant #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  // cand_idx[k] is the requester examined k-th in the cyclic search order.
  logic [IDW:0]   cand_sum [NREQ];
  logic [IDW-1:0] cand_idx [NREQ];

  // ptr is always below NREQ, so one conditional subtraction implements the wrap.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, ptr} + (IDW+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(NREQ)) ?
                            IDW'(cand_sum[gi] - (IDW+1)'(NREQ)) :
                            cand_sum[gi][IDW-1:0];
    end
  endgenerate

  // Scan from the back of the search order so the earliest valid candidate wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant_idx = cand_idx[k];
        any_valid = 1'b1;
      end
    end
    if (any_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external registered adder among NREQ requesters.
// Round-robin grant, one operation in flight, tagged response with backpressure.
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = tag_width(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          REQ_VALID,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic [NREQ*DATA_W-1:0]   REQ_A,
  input  logic [NREQ*DATA_W-1:0]   REQ_B,
  output logic [DATA_W-1:0]        ADD_IN1,
  output logic [DATA_W-1:0]        ADD_IN2,
  input  logic [DATA_W-1:0]        ADD_OUT,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [IDW-1:0]           RSP_ID,
  output logic [DATA_W-1:0]        RSP_DATA,
  output logic                     BUSY
);

  state_t             state_reg, state_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [IDW-1:0]     tag_reg, tag_next;
  logic [DATA_W-1:0]  op_a_reg, op_a_next;
  logic [DATA_W-1:0]  op_b_reg, op_b_next;

  logic [DATA_W-1:0]  req_a_arr [NREQ];
  logic [DATA_W-1:0]  req_b_arr [NREQ];

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_valid;
  logic               accept;

  // Unpack the flat operand buses into per-requester words.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = REQ_A[DATA_W*gi +: DATA_W];
      assign req_b_arr[gi] = REQ_B[DATA_W*gi +: DATA_W];
    end
  endgenerate

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req_valid (REQ_VALID),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  // Next-state logic: accept in IDLE, or in DONE when the response leaves this cycle.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    tag_next   = tag_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    accept     = 1'b0;
    RSP_VALID  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // While reset is held the FSM sits in IDLE; no grant may be offered then.
        accept = any_valid & rst_n;
      end
      ST_CALC: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          if (any_valid) begin
            accept = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    if (accept) begin
      op_a_next  = req_a_arr[grant_idx];
      op_b_next  = req_b_arr[grant_idx];
      tag_next   = grant_idx;
      ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      state_next = ST_CALC;
    end
  end

  // FSM, pointer, tag and operand registers; operands only move on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      tag_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      tag_reg   <= tag_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
    end
  end

  assign REQ_READY = accept ? grant : '0;
  assign ADD_IN1   = op_a_reg;
  assign ADD_IN2   = op_b_reg;
  assign RSP_ID    = tag_reg;
  assign RSP_DATA  = ADD_OUT;
  assign BUSY      = (state_reg != ST_IDLE);

endmodule
